// File: rtl/photo_frame_fx_pkg.sv
// photo_frame_fx_pkg: shared types and helpers for the photo-frame effect engine.
package photo_frame_fx_pkg;

    localparam int COLOR_W = 12;

    // Effect selected by mode_sel when start is pulsed.
    typedef enum logic [1:0] {
        FX_STATIC  = 2'd0,
        FX_SCROLL  = 2'd1,
        FX_SPLIT_V = 2'd2,
        FX_SPLIT_H = 2'd3
    } fx_mode_e;

    // Animation controller states. ST_CLOSING is only reachable when the
    // closing animation is built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_SPLIT_V,
        ST_SPLIT_H,
        ST_OPEN,
        ST_CLOSING
    } fx_state_e;

    // ROM address width for a w x h image.
    function automatic int ADDR_W(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/photo_frame_fx_addr_gen.sv
// fx_addr_gen: stage-0 of the effect pipeline. Maps the screen coordinate to a
// ROM address (with vertical scroll wrap and split-open shifting), decides
// whether the pixel is visible, and registers both.
module fx_addr_gen #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int SCALE = 1,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480,
    parameter int OFS_W = 8,
    parameter int GAP_W = 9,
    parameter int AW    = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       h_cnt_i,
    input  logic [9:0]       v_cnt_i,
    input  logic             valid_i,
    input  logic [OFS_W-1:0] offset_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             split_v_i,
    input  logic             split_h_i,
    input  logic             blank_i,
    output logic [AW-1:0]    pixel_addr_o,
    output logic             show_o
);
    import photo_frame_fx_pkg::*;

    // One bit wider than the counters so coordinate + gap never overflows.
    localparam int            CW       = 11;
    localparam int            HALF_W   = SCR_W / 2;
    localparam int            HALF_H   = SCR_H / 2;
    localparam logic [CW-1:0] HALF_W_C = HALF_W[CW-1:0];
    localparam logic [CW-1:0] HALF_H_C = HALF_H[CW-1:0];
    localparam logic [CW-1:0] IMG_H_C  = IMG_H[CW-1:0];

    logic [CW-1:0] h_x, v_x, gap_x;
    logic [CW-1:0] src_h, src_v;
    logic [CW-1:0] sx, sy, row;
    logic          mask;
    logic [AW-1:0] pixel_addr_d, pixel_addr_q;
    logic          show_d, show_q;

    assign h_x   = {1'b0, h_cnt_i};
    assign v_x   = {1'b0, v_cnt_i};
    assign gap_x = CW'(gap_i);

    // Source coordinate, mask and wrapped ROM address for the current pixel.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and a latch is inferred.
        src_h = h_x;
        src_v = v_x;
        mask  = 1'b0;

        // Each half slides away from the centre by gap; the band between is black.
        if (split_v_i) begin
            if (v_x < HALF_H_C - gap_x) begin
                src_v = v_x + gap_x;
            end else if (v_x >= HALF_H_C + gap_x) begin
                src_v = v_x - gap_x;
            end else begin
                mask = 1'b1;
            end
        end

        if (split_h_i) begin
            if (h_x < HALF_W_C - gap_x) begin
                src_h = h_x + gap_x;
            end else if (h_x >= HALF_W_C + gap_x) begin
                src_h = h_x - gap_x;
            end else begin
                mask = 1'b1;
            end
        end

        if (blank_i) begin
            mask = 1'b1;
        end

        sx  = src_h >> SCALE;
        sy  = src_v >> SCALE;
        // offset < IMG_H and sy < IMG_H on visible pixels, so one subtract wraps.
        row = sy + CW'(offset_i);
        if (row >= IMG_H_C) begin
            row = row - IMG_H_C;
        end

        pixel_addr_d = AW'(32'(row) * 32'(IMG_W) + 32'(sx));
        show_d       = valid_i & ~mask;
    end

    // Stage-0 output register: address to the ROM, visibility to the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr_q <= '0;
            show_q       <= 1'b0;
        end else begin
            pixel_addr_q <= pixel_addr_d;
            show_q       <= show_d;
        end
    end

    assign pixel_addr_o = pixel_addr_q;
    assign show_o       = show_q;

endmodule

// File: rtl/photo_frame_fx.sv
// photo_frame_fx: display-effect engine between vga_controller and the image
// ROM. Static view, continuous vertical scroll and vertical/horizontal
// split-open transitions, stepped by an external tick.
// Build option: define PHOTO_FRAME_FX_CLOSE_EN to make OPEN close again
// (CLOSING state) instead of holding until the next start.
// pixel_in must carry the word for the h_cnt/v_cnt presented MEM_LAT cycles
// earlier (MEM_LAT-1 cycles after pixel_addr); rgb follows one cycle later.
module photo_frame_fx #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int SCALE   = 1,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int STEP    = 2,
    parameter int MEM_LAT = 1,
    parameter int COLOR_W = photo_frame_fx_pkg::COLOR_W
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            tick,
    input  logic                                            start,
    input  logic [1:0]                                      mode_sel,
    input  logic                                            valid,
    input  logic [9:0]                                      h_cnt,
    input  logic [9:0]                                      v_cnt,
    input  logic [COLOR_W-1:0]                              pixel_in,
    output logic [photo_frame_fx_pkg::ADDR_W(IMG_W, IMG_H)-1:0] pixel_addr,
    output logic [COLOR_W-1:0]                              rgb,
    output logic                                            busy,
    output logic                                            done
);
    import photo_frame_fx_pkg::*;

    localparam int AW       = ADDR_W(IMG_W, IMG_H);
    localparam int OFS_W    = $clog2(IMG_H);
    localparam int HALF_W   = SCR_W / 2;
    localparam int HALF_H   = SCR_H / 2;
    localparam int HALF_MAX = (HALF_W > HALF_H) ? HALF_W : HALF_H;
    localparam int GAP_W    = $clog2(HALF_MAX + 1);

    localparam logic [OFS_W:0] IMG_H_O  = IMG_H[OFS_W:0];
    localparam logic [GAP_W:0] STEP_G   = STEP[GAP_W:0];
    localparam logic [GAP_W:0] HALF_W_G = HALF_W[GAP_W:0];
    localparam logic [GAP_W:0] HALF_H_G = HALF_H[GAP_W:0];

    fx_state_e        state_q, state_d;
    logic [OFS_W-1:0] offset_q, offset_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W:0]   gap_sum;
    logic [OFS_W:0]   offset_inc;
    logic             split_v, split_h, blank;
    logic             show_s0, show_aligned;
    logic [COLOR_W-1:0] rgb_q;

`ifdef PHOTO_FRAME_FX_CLOSE_EN
    logic dir_h_q, dir_h_d;
    logic done_pulse_q, done_pulse_d;
`endif

    assign gap_sum    = {1'b0, gap_q} + STEP_G;
    assign offset_inc = {1'b0, offset_q} + 1'b1;

    // Animation FSM state, scroll offset and split gap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= ST_IDLE;
            offset_q <= '0;
            gap_q    <= '0;
`ifdef PHOTO_FRAME_FX_CLOSE_EN
            dir_h_q      <= 1'b0;
            done_pulse_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            gap_q    <= gap_d;
`ifdef PHOTO_FRAME_FX_CLOSE_EN
            dir_h_q      <= dir_h_d;
            done_pulse_q <= done_pulse_d;
`endif
        end
    end

    // Next-state logic; start is checked before tick so a coincident tick is dropped.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        gap_d    = gap_q;
`ifdef PHOTO_FRAME_FX_CLOSE_EN
        dir_h_d      = dir_h_q;
        done_pulse_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (fx_mode_e'(mode_sel))
                        FX_SCROLL: state_d = ST_SCROLL;
                        FX_SPLIT_V: begin
                            state_d = ST_SPLIT_V;
                            gap_d   = '0;
`ifdef PHOTO_FRAME_FX_CLOSE_EN
                            dir_h_d = 1'b0;
`endif
                        end
                        FX_SPLIT_H: begin
                            state_d = ST_SPLIT_H;
                            gap_d   = '0;
`ifdef PHOTO_FRAME_FX_CLOSE_EN
                            dir_h_d = 1'b1;
`endif
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SCROLL: begin
                // Leaving keeps the offset so the static view stays scrolled.
                if (start) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    offset_d = (offset_inc == IMG_H_O) ? '0 : offset_inc[OFS_W-1:0];
                end
            end
            ST_SPLIT_V: begin
                if (tick) begin
                    if (gap_sum >= HALF_H_G) begin
                        gap_d   = HALF_H_G[GAP_W-1:0];
                        state_d = ST_OPEN;
                    end else begin
                        gap_d = gap_sum[GAP_W-1:0];
                    end
                end
            end
            ST_SPLIT_H: begin
                if (tick) begin
                    if (gap_sum >= HALF_W_G) begin
                        gap_d   = HALF_W_G[GAP_W-1:0];
                        state_d = ST_OPEN;
                    end else begin
                        gap_d = gap_sum[GAP_W-1:0];
                    end
                end
            end
            ST_OPEN: begin
                if (start) begin
                    state_d  = ST_IDLE;
                    gap_d    = '0;
                    offset_d = '0;
                end
`ifdef PHOTO_FRAME_FX_CLOSE_EN
                else if (tick) begin
                    state_d = ST_CLOSING;
                end
`endif
            end
`ifdef PHOTO_FRAME_FX_CLOSE_EN
            ST_CLOSING: begin
                if (tick) begin
                    if ({1'b0, gap_q} <= STEP_G) begin
                        gap_d        = '0;
                        state_d      = ST_IDLE;
                        done_pulse_d = 1'b1;
                    end else begin
                        gap_d = gap_q - STEP_G[GAP_W-1:0];
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Mapping controls and status outputs decoded from the current state.
    always_comb begin
        split_v = (state_q == ST_SPLIT_V);
        split_h = (state_q == ST_SPLIT_H);
        blank   = (state_q == ST_OPEN);
        busy    = (state_q == ST_SCROLL) || (state_q == ST_SPLIT_V) || (state_q == ST_SPLIT_H);
        done    = (state_q == ST_OPEN);
`ifdef PHOTO_FRAME_FX_CLOSE_EN
        if (state_q == ST_CLOSING) begin
            split_v = ~dir_h_q;
            split_h = dir_h_q;
            busy    = 1'b1;
        end
        done = done | done_pulse_q;
`endif
    end

    fx_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .SCALE (SCALE),
        .SCR_W (SCR_W),
        .SCR_H (SCR_H),
        .OFS_W (OFS_W),
        .GAP_W (GAP_W),
        .AW    (AW)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .h_cnt_i      (h_cnt),
        .v_cnt_i      (v_cnt),
        .valid_i      (valid),
        .offset_i     (offset_q),
        .gap_i        (gap_q),
        .split_v_i    (split_v),
        .split_h_i    (split_h),
        .blank_i      (blank),
        .pixel_addr_o (pixel_addr),
        .show_o       (show_s0)
    );

    // The stage-0 register is the first of the MEM_LAT visibility delay stages.
    if (MEM_LAT == 1) begin : g_no_dly
        assign show_aligned = show_s0;
    end else begin : g_dly
        logic [MEM_LAT-2:0] dly_q;

        // Remaining visibility delay stages matching the ROM read latency.
        always_ff @(posedge clk) begin
            // NOTE: these delay flops are reset so rgb cannot show stale visibility straight after rst.
            if (rst) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= show_s0;
                for (int i = 1; i < MEM_LAT - 1; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign show_aligned = dly_q[MEM_LAT-2];
    end

    // Output colour register: ROM data when visible, black otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= show_aligned ? pixel_in : '0;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_photo_frame_fx.sv
// tb_photo_frame_fx: directed self-checking bench for photo_frame_fx with
// default parameters. The ROM is modelled as an address-derived pattern.
`timescale 1ns/1ps
module tb_photo_frame_fx;

    localparam int AW = 17;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst, tick, start, valid;
    logic [1:0]    mode_sel;
    logic [9:0]    h_cnt, v_cnt;
    logic [CW-1:0] pixel_in, rgb;
    logic [AW-1:0] pixel_addr;
    logic          busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] rom_f(input logic [AW-1:0] a);
        return a[11:0] ^ 12'hA5C ^ {7'd0, a[16:12]};
    endfunction

    // ROM with its word available for the registered address (MEM_LAT = 1).
    assign pixel_in = rom_f(pixel_addr);

    photo_frame_fx dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .mode_sel   (mode_sel),
        .valid      (valid),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .pixel_in   (pixel_in),
        .pixel_addr (pixel_addr),
        .rgb        (rgb),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic do_start(input logic [1:0] m);
        start    = 1'b1;
        mode_sel = m;
        step();
        start    = 1'b0;
    endtask

    // Visible pixel: address one cycle later, ROM colour one cycle after that.
    task automatic probe_px(input string tag, input int h, input int v, input int exp_addr);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = 1'b1;
        step();
        check({tag, ".addr"}, 32'(pixel_addr), exp_addr);
        step();
        check({tag, ".rgb"}, 32'(rgb), 32'(rom_f(AW'(exp_addr))));
    endtask

    // Pixel that must come out black (masked or outside the visible area).
    task automatic probe_black(input string tag, input int h, input int v, input logic vld);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = vld;
        step();
        step();
        check({tag, ".rgb"}, 32'(rgb), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; valid = 1'b0;
        mode_sel = 2'd0; h_cnt = '0; v_cnt = '0;

        // Reset state.
        do_reset();
        check("rst.addr", 32'(pixel_addr), 0);
        check("rst.rgb",  32'(rgb), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);

        // Static view corners and the valid gate.
        probe_px("static.origin", 0, 0, 0);
        probe_px("static.corner", 639, 479, 76799);
        probe_black("static.invalid", 100, 100, 1'b0);
        do_start(2'd0);
        check("static.start.busy", 32'(busy), 0);

        // Scroll: offset counts 1..239, wraps to 0, then 1.
        do_start(2'd1);
        check("scroll.busy", 32'(busy), 1);
        for (int k = 1; k <= 241; k++) begin
            do_tick();
            if (k == 1 || k == 239 || k == 240 || k == 241)
                probe_px($sformatf("scroll.t%0d", k), 0, 0, (k % 240) * 320);
        end
        probe_px("scroll.rowwrap", 0, 479, 0);

        // start with tick in SCROLL: back to IDLE, offset held, tick dropped.
        tick = 1'b1;
        do_start(2'd0);
        tick = 1'b0;
        check("scroll.exit.busy", 32'(busy), 0);
        probe_px("scroll.held", 0, 0, 320);

        // start with tick in IDLE: SCROLL entered, offset untouched.
        tick = 1'b1;
        do_start(2'd1);
        tick = 1'b0;
        check("idle.starttick.busy", 32'(busy), 1);
        probe_px("idle.starttick.addr", 0, 0, 320);
        do_start(2'd0);

        // Vertical split.
        do_reset();
        do_start(2'd2);
        check("splitv.busy", 32'(busy), 1);
        ticks(10);
        probe_px("splitv.top", 5, 100, 19202);
        probe_px("splitv.topedge", 5, 219, 38082);
        probe_black("splitv.gap.lo", 5, 220, 1'b1);
        probe_black("splitv.gap.mid", 5, 230, 1'b1);
        probe_px("splitv.bottom", 5, 300, 44802);
        ticks(109);
        check("splitv.t119.done", 32'(done), 0);
        check("splitv.t119.busy", 32'(busy), 1);
        do_tick();
        check("splitv.t120.done", 32'(done), 1);
        check("splitv.t120.busy", 32'(busy), 0);
        probe_black("open.black", 0, 0, 1'b1);
        do_start(2'd0);
        check("open.exit.done", 32'(done), 0);
        probe_px("open.exit.addr", 0, 0, 0);

        // Horizontal split; start mid-split is ignored.
        do_start(2'd3);
        ticks(5);
        do_start(2'd0);
        check("splith.start.busy", 32'(busy), 1);
        probe_px("splith.left", 300, 0, 155);
        probe_black("splith.gap", 315, 0, 1'b1);
        ticks(154);
        check("splith.t159.done", 32'(done), 0);
        do_tick();
        check("splith.t160.done", 32'(done), 1);
        do_start(2'd0);

        // Reset mid-animation at gap = 40.
        do_start(2'd2);
        ticks(20);
        probe_px("abort.gap40", 5, 100, 22402);
        rst = 1'b1;
        step();
        check("abort.busy", 32'(busy), 0);
        check("abort.rgb",  32'(rgb), 0);
        check("abort.addr", 32'(pixel_addr), 0);
        rst = 1'b0;
        probe_px("abort.gap0", 5, 100, 16002);

`ifdef PHOTO_FRAME_FX_CLOSE_EN
        // Closing animation returns to IDLE with a one-cycle done pulse.
        do_start(2'd2);
        ticks(120);
        check("close.open.done", 32'(done), 1);
        do_tick();
        check("close.enter.busy", 32'(busy), 1);
        check("close.enter.done", 32'(done), 0);
        ticks(119);
        check("close.t119.busy", 32'(busy), 1);
        do_tick();
        check("close.end.done", 32'(done), 1);
        check("close.end.busy", 32'(busy), 0);
        step();
        check("close.pulse.done", 32'(done), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/photo_frame_fx.md
Name: photo_frame_fx

Overview:
- Parametrised display-effect engine for the VGA photo frame.
- Sits between vga_controller (h_cnt/v_cnt/valid) and the single-port image ROM.
- Generates the ROM read address per pixel and drives the 12-bit colour output.
- Runs a start-triggered state machine: static view, continuous vertical scroll, and vertical/horizontal split-open transitions. Animation speed is set by an external tick.

Parameters:
- IMG_W, 320, source image width in pixels.
- IMG_H, 240, source image height in pixels.
- SCALE, 1, log2 upscale factor; screen coordinate >> SCALE gives image coordinate.
- SCR_W, 640, visible screen width; must equal IMG_W << SCALE.
- SCR_H, 480, visible screen height; must equal IMG_H << SCALE.
- STEP, 2, split gap growth per tick, in screen pixels.
- MEM_LAT, 1, ROM read latency in clk cycles (1..3).
- COLOR_W, 12, colour width.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle animation step pulse.
- start  in  1  one-cycle command pulse.
- mode_sel  in  2  0=static, 1=scroll, 2=split vertical, 3=split horizontal; sampled on start.
- valid  in  1  visible-area flag from vga_controller.
- h_cnt  in  10  screen column.
- v_cnt  in  10  screen row.
- pixel_in  in  COLOR_W  ROM read data.
- pixel_addr  out  $clog2(IMG_W*IMG_H)  ROM read address.
- rgb  out  COLOR_W  {R,G,B} to the VGA pins.
- busy  out  1  high in SCROLL, SPLIT_V, SPLIT_H.
- done  out  1  high in OPEN.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, offset=0, gap=0, pixel_addr=0, rgb=0, busy=0, done=0.
  - Reset mid-animation aborts to IDLE immediately.
- States: IDLE, SCROLL, SPLIT_V, SPLIT_H, OPEN.
- From IDLE, start with mode_sel:
  - 0: stay in IDLE.
  - 1: go to SCROLL.
  - 2: go to SPLIT_V with gap=0.
  - 3: go to SPLIT_H with gap=0.
- SCROLL:
  - Each tick: offset = (offset+1 == IMG_H) ? 0 : offset+1.
  - start returns to IDLE; offset is held, so the static view keeps the scrolled position.
- SPLIT_V: each tick, gap += STEP, saturating at SCR_H/2. When gap reaches SCR_H/2, go to OPEN.
- SPLIT_H: same as SPLIT_V with limit SCR_W/2.
- OPEN: screen fully black, done=1. start clears gap and offset and goes to IDLE.
- start is ignored in SPLIT_V and SPLIT_H.
- start and tick in the same cycle: the start transition wins; the tick is dropped.
- Address mapping, stage 0, registered:
  - sx = h_cnt>>SCALE, sy = v_cnt>>SCALE.
  - row = sy + offset; subtract IMG_H if row >= IMG_H (single conditional subtract, no % operator).
  - pixel_addr = row*IMG_W + sx.
- Split mapping:
  - SPLIT_V:
    - Top half shows source row v_cnt+gap when v_cnt < SCR_H/2 - gap.
    - Bottom half shows source row v_cnt-gap when v_cnt >= SCR_H/2 + gap.
    - Everything else is masked.
  - SPLIT_H: the same rule applied to h_cnt against SCR_W/2.
- Masking:
  - The mask bit is computed in stage 0 alongside the address.
  - Masked pixels and valid=0 pixels output rgb=0.
- Latency:
  - valid and mask are delayed through a MEM_LAT-deep shift register.
  - rgb = aligned ? pixel_in : 0, registered.
  - Total latency from h_cnt/v_cnt to rgb is MEM_LAT+1 clocks.
- Offset and gap change only on tick, never mid-cycle-dependent. The team's divided tick is one pulse per frame-rate step.

Optional Feature:
- Macro: PHOTO_FRAME_FX_CLOSE_EN.
- Defined:
  - OPEN is not terminal. On the next tick, the FSM enters CLOSING.
  - CLOSING decrements gap by STEP per tick, floored at 0.
  - When gap reaches 0, go to IDLE with done pulsing high for one cycle.
  - busy stays high throughout CLOSING.
  - CLOSING reuses the split direction latched on the original start.
- Undefined: behaviour exactly as above; OPEN holds until start.

Decomposition:
- Package photo_frame_fx_pkg holds:
  - the fx_mode_e enum (STATIC, SCROLL, SPLIT_V, SPLIT_H);
  - the fx_state_e enum;
  - COLOR_W and the ADDR_W helper function.
- One sub-module, fx_addr_gen: the stage-0 combinational address and mask computation plus its output register.
- The FSM and latency pipeline stay in the top module.

Test Plan:
- Reset, then scan (h=0,v=0) and (h=639,v=479) with default parameters → pixel_addr = 0 and 76799; rgb equals pixel_in MEM_LAT+1 cycles later; busy=0, done=0.
- start with mode=1, then 241 ticks → offset sequence 1..239, 0, 1. At (h=0,v=0), pixel_addr = 320*offset, wrapping to 0 after offset 239.
- start with mode=2, 120 ticks → done=1 after the 120th tick. After tick 10 (gap=20): (h=5,v=100) → addr = 5>>1 + 320*(120>>1) = 19202; (h=5,v=230) → rgb=0.
- start with mode=3 → SPLIT_H; OPEN reached after 160 ticks. Assert start mid-split → state unchanged.
- rst asserted during SPLIT_V at gap=40 → next cycle state=IDLE, gap=0, rgb=0, busy=0.
- With PHOTO_FRAME_FX_CLOSE_EN, mode=2: 120 ticks to OPEN, 1 tick to CLOSING, 120 ticks back to IDLE → done pulses high for one cycle. Also: start and tick in the same cycle in IDLE → only the start transition takes effect.
